// File: rtl/proc_feeder.sv
// Instruction sequencer for the 9-bit mv/mvi/add/sub processor: holds a small
// program memory and drives Run/DIN one instruction at a time, advancing on Done.
module proc_feeder #(
    parameter int unsigned AW      = 4,
    parameter int unsigned TIMEOUT = 7
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          load_en_i,
    input  logic [AW-1:0] load_addr_i,
    input  logic [8:0]    load_data_i,
    input  logic [AW:0]   prog_len_i,
    output logic [8:0]    din_o,
    output logic          run_o,
    input  logic          done_i,
    output logic          busy_o,
    output logic          finished_o,
    output logic          error_o,
    output logic [AW-1:0] pc_o,
    output logic [AW:0]   instr_count_o
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned WW    = 9;
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned TW    = $clog2(TIMEOUT + 1);
    // Last watchdog value before expiry: ERR then lands TIMEOUT cycles after ISSUE.
    localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 2);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_ISSUE, S_DATA, S_WAIT, S_FINISH, S_ERR
    } state_e;

    state_e        state_q, state_d;
    logic [WW-1:0] mem_q [DEPTH];
    logic [PW-1:0] len_q, len_d;
    logic [PW-1:0] pc_q, pc_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] wd_q, wd_d;
    logic          err_q, err_d;
    logic [WW-1:0] din_q, din_d;
    logic          run_q, run_d;
    logic          busy_q, busy_d;
    logic          fin_q, fin_d;

    logic [PW-1:0] pc_inc1, pc_inc2, pc_adv;
    logic [WW-1:0] word_cur, word_nxt;
    logic [2:0]    op;
    logic          is_mvi, idle_like, start_ok, load_ok;

    assign pc_inc1   = pc_q + PW'(1);
    assign pc_inc2   = pc_q + PW'(2);
    assign word_cur  = mem_q[pc_q[AW-1:0]];
    assign word_nxt  = mem_q[pc_inc1[AW-1:0]];
    assign op        = word_cur[8:6];
    assign is_mvi    = (op == 3'b001);
    assign pc_adv    = is_mvi ? pc_inc2 : pc_inc1;
    assign idle_like = (state_q == S_IDLE) || (state_q == S_FINISH) || (state_q == S_ERR);
    assign start_ok  = start_i && idle_like;
    assign load_ok   = load_en_i && idle_like;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        wd_d    = wd_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE, S_FINISH, S_ERR: begin
                state_d = S_IDLE;
                if (start_ok) begin
                    len_d = prog_len_i;
                    pc_d  = '0;
                    cnt_d = '0;
                    err_d = 1'b0;
                    if (prog_len_i == '0) begin
                        state_d = S_FINISH;
                    end else if (prog_len_i > PW'(DEPTH)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_CHECK;
                    end
                end
            end
            // Illegal opcodes never complete, and mvi needs its data word in range.
            S_CHECK: begin
                if (op[2]) begin
                    state_d = S_ERR;
                end else if (is_mvi && (pc_inc1 >= len_q)) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = is_mvi ? S_DATA : S_WAIT;
            end
            S_DATA, S_WAIT: begin
                if (done_i) begin
                    pc_d    = pc_adv;
                    cnt_d   = cnt_q + PW'(1);
                    state_d = (pc_adv >= len_q) ? S_FINISH : S_CHECK;
                end else if (wd_q == WD_LAST) begin
                    state_d = S_ERR;
                end else begin
                    wd_d    = wd_q + TW'(1);
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_ERR) begin
            err_d = 1'b1;
        end
    end

    // Processor-facing outputs are registered copies of the next state's decode.
    always_comb begin
        run_d  = (state_d == S_ISSUE);
        fin_d  = (state_d == S_FINISH);
        busy_d = (state_d == S_CHECK) || (state_d == S_ISSUE) ||
                 (state_d == S_DATA)  || (state_d == S_WAIT);
        din_d  = '0;
        if (state_d == S_ISSUE) begin
            din_d = word_cur;
        end else if (state_d == S_DATA) begin
            din_d = word_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            pc_q    <= '0;
            cnt_q   <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
            din_q   <= '0;
            run_q   <= 1'b0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            din_q   <= din_d;
            run_q   <= run_d;
            busy_q  <= busy_d;
            fin_q   <= fin_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (load_ok) begin
            mem_q[load_addr_i] <= load_data_i;
        end
    end

    assign din_o         = din_q;
    assign run_o         = run_q;
    assign busy_o        = busy_q;
    assign finished_o    = fin_q;
    assign error_o       = err_q;
    assign pc_o          = pc_q[AW-1:0];
    assign instr_count_o = cnt_q;

endmodule

// File: tb/tb_proc_feeder.sv
// Bench for proc_feeder: behavioural 9-bit processor model plus an event
// scoreboard checking Run/DIN words, Finished and Error with their cycle offsets.
module tb_proc_feeder;

    localparam int unsigned AW = 4;
    localparam int unsigned PW = AW + 1;
    localparam logic [1:0] K_RUN = 2'd0;
    localparam logic [1:0] K_DAT = 2'd1;
    localparam logic [1:0] K_FIN = 2'd2;
    localparam logic [1:0] K_ERR = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [8:0]  data;
        logic [15:0] off;
    } ev_t;

    logic          clk, rst, start, load_en, done;
    logic [AW-1:0] load_addr;
    logic [8:0]    load_data;
    logic [AW:0]   prog_len;
    logic [8:0]    din;
    logic          run, busy, finished, error;
    logic [AW-1:0] pc;
    logic [AW:0]   instr_count;

    int  n_chk = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  start_cyc = 0;
    ev_t q[$];

    proc_feeder #(.AW(AW), .TIMEOUT(7)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .load_en_i(load_en),
        .load_addr_i(load_addr), .load_data_i(load_data), .prog_len_i(prog_len),
        .din_o(din), .run_o(run), .done_i(done), .busy_o(busy),
        .finished_o(finished), .error_o(error), .pc_o(pc),
        .instr_count_o(instr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (start) start_cyc <= cyc + 1;
    end

    // Processor model: IR in T0, mv/mvi finish in T1, add/sub in T3.
    logic [8:0] r [8];
    logic [8:0] ir, ra, rg;
    logic [1:0] tstep;
    logic       hold, done_raw;

    always_comb begin
        done_raw = ((tstep == 2'd1) && (ir[8:7] == 2'b00)) || (tstep == 2'd3);
        done     = done_raw && !hold;
    end

    always @(posedge clk) begin
        if (rst) begin
            tstep <= 2'd0;
            ir    <= '0;
            for (int i = 0; i < 8; i++) r[i] <= '0;
        end else begin
            case (tstep)
                2'd0: if (run) begin ir <= din; tstep <= 2'd1; end
                2'd1: begin
                    if (ir[8:6] == 3'b000) begin
                        r[ir[5:3]] <= r[ir[2:0]];
                        tstep <= 2'd0;
                    end else if (ir[8:6] == 3'b001) begin
                        r[ir[5:3]] <= din;
                        tstep <= 2'd0;
                    end else begin
                        ra    <= r[ir[5:3]];
                        tstep <= 2'd2;
                    end
                end
                2'd2: begin
                    rg    <= ir[6] ? ra - r[ir[2:0]] : ra + r[ir[2:0]];
                    tstep <= 2'd3;
                end
                default: begin
                    r[ir[5:3]] <= rg;
                    tstep <= 2'd0;
                end
            endcase
        end
    end

    // Monitor: every visible DUT event is matched against the head of the queue.
    logic err_prev = 1'b0;
    always @(negedge clk) begin
        ev_t got, exp_e;
        logic hit;
        if (!rst) begin
            hit = 1'b1;
            got.data = '0;
            if (run) begin
                got.kind = K_RUN; got.data = din;
            end else if (din != '0) begin
                got.kind = K_DAT; got.data = din;
            end else if (finished) begin
                got.kind = K_FIN;
            end else if (error && !err_prev) begin
                got.kind = K_ERR; got.data = 9'(pc);
            end else begin
                got.kind = K_RUN; hit = 1'b0;
            end
            got.off = 16'(cyc - start_cyc);
            if (hit) begin
                n_chk++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event got kind=%0d data=%h off=%0d, want none",
                             got.kind, got.data, got.off);
                end else begin
                    exp_e = q.pop_front();
                    if (got !== exp_e) begin
                        n_fail++;
                        $display("FAIL event got kind=%0d data=%h off=%0d, want kind=%0d data=%h off=%0d",
                                 got.kind, got.data, got.off, exp_e.kind, exp_e.data, exp_e.off);
                    end
                end
            end
        end
        err_prev = error;
    end

    task automatic expect_ev(input logic [1:0] k, input int d, input int o);
        ev_t e;
        e.kind = k;
        e.data = 9'(d);
        e.off  = 16'(o);
        q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int want);
        n_chk++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s got %0d want %0d", name, act, want);
        end
    endtask

    task automatic load(input int a, input int d);
        load_en = 1'b1; load_addr = AW'(a); load_data = 9'(d);
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic start_prog(input int len, input bit ld, input int a, input int d);
        prog_len = PW'(len);
        start = 1'b1;
        if (ld) begin
            load_en = 1'b1; load_addr = AW'(a); load_data = 9'(d);
        end
        @(negedge clk);
        start = 1'b0; load_en = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        if (q.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL drain_timeout got %0d pending events want 0", q.size());
            q.delete();
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; load_en = 1'b0; hold = 1'b0;
        load_addr = '0; load_data = '0; prog_len = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("reset_din", int'(din), 0);
        chk("reset_run", int'(run), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_finished", int'(finished), 0);
        chk("reset_error", int'(error), 0);
        chk("reset_pc", int'(pc), 0);
        chk("reset_count", int'(instr_count), 0);

        // mvi r0,5 ; add r0,r0
        load(0, 9'h040); load(1, 9'h005); load(2, 9'h080);
        expect_ev(K_RUN, 9'h040, 1); expect_ev(K_DAT, 9'h005, 2);
        expect_ev(K_RUN, 9'h080, 4); expect_ev(K_FIN, 0, 8);
        start_prog(3, 1'b0, 0, 0);
        drain();
        chk("t1_r0", int'(r[0]), 10);
        chk("t1_count", int'(instr_count), 2);
        chk("t1_error", int'(error), 0);
        chk("t1_pc", int'(pc), 3);
        chk("t1_busy", int'(busy), 0);

        // mv r1,r0 ; sub r0,r1 (second word written in the Start cycle)
        load(0, 9'h008);
        expect_ev(K_RUN, 9'h008, 1); expect_ev(K_RUN, 9'h0C1, 4); expect_ev(K_FIN, 0, 8);
        start_prog(2, 1'b1, 1, 9'h0C1);
        drain();
        chk("t2_r0", int'(r[0]), 0);
        chk("t2_r1", int'(r[1]), 10);
        chk("t2_pc", int'(pc), 2);
        chk("t2_count", int'(instr_count), 2);

        // illegal opcode
        load(0, 9'h100);
        expect_ev(K_ERR, 0, 1);
        start_prog(1, 1'b0, 0, 0);
        drain();
        chk("t3_error", int'(error), 1);
        chk("t3_pc", int'(pc), 0);
        chk("t3_busy", int'(busy), 0);

        // mvi with missing data word, then empty and oversized programs
        load(0, 9'h040);
        expect_ev(K_ERR, 0, 1);
        start_prog(1, 1'b0, 0, 0);
        drain();
        chk("t4_mvi_last_error", int'(error), 1);
        expect_ev(K_FIN, 0, 0);
        start_prog(0, 1'b0, 0, 0);
        drain();
        chk("t4_len0_error", int'(error), 0);
        chk("t4_len0_count", int'(instr_count), 0);
        expect_ev(K_ERR, 0, 0);
        start_prog(17, 1'b0, 0, 0);
        drain();
        chk("t4_len17_error", int'(error), 1);

        // Done held low: watchdog
        load(0, 9'h080);
        hold = 1'b1;
        expect_ev(K_RUN, 9'h080, 1); expect_ev(K_ERR, 0, 8);
        start_prog(1, 1'b0, 0, 0);
        drain();
        hold = 1'b0;
        expect_ev(K_RUN, 9'h080, 1); expect_ev(K_FIN, 0, 5);
        start_prog(1, 1'b0, 0, 0);
        #1;
        chk("t5_start_clears_error", int'(error), 0);
        drain();
        chk("t5_count", int'(instr_count), 1);

        // reset during WAIT of add, with a load attempted while busy
        expect_ev(K_RUN, 9'h080, 1);
        start_prog(1, 1'b0, 0, 0);
        load(0, 9'h100);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("t6_reset_run", int'(run), 0);
        chk("t6_reset_busy", int'(busy), 0);
        chk("t6_reset_count", int'(instr_count), 0);
        rst = 1'b0;
        @(negedge clk);
        expect_ev(K_RUN, 9'h080, 1); expect_ev(K_FIN, 0, 5);
        start_prog(1, 1'b0, 0, 0);
        drain();
        chk("t6_rerun_error", int'(error), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/proc_feeder.md
Name: proc_feeder

Overview:
- Instruction sequencer that drives the Run/DIN/Done handshake of the 9-bit mv/mvi/add/sub processor from the initiator side.
- Holds a small loadable program memory and issues words to the processor one instruction at a time, including the mvi data word.
- Waits for Done, then advances to the next instruction.
- Sits between a host/loader and the processor's DIN, Run and Done pins.

Parameters:
- AW, 4, program memory address width; DEPTH = 2**AW words of 9 bits.
- TIMEOUT, 7, maximum cycles spent waiting for Done after an issue before Error is raised.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  one-cycle pulse; begins execution at address 0; ignored while Busy.
- LoadEn  input  1  write LoadData to mem[LoadAddr]; ignored while Busy.
- LoadAddr  input  AW  program memory write address.
- LoadData  input  9  program word, format III XXX YYY.
- ProgLen  input  AW+1  number of memory words to execute; latched on Start.
- DIN  output  9  word presented to the processor.
- Run  output  1  instruction-valid strobe to the processor.
- Done  input  1  processor completion; combinational from the processor, sampled every cycle.
- Busy  output  1  high from the accepted Start until FINISH/ERR.
- Finished  output  1  one-cycle pulse on normal completion.
- Error  output  1  sticky; cleared by Reset or an accepted Start.
- PC  output  AW  address of the current instruction word.
- InstrCount  output  AW+1  instructions completed since the last accepted Start.

Behaviour:
- Reset: state IDLE; DIN=0, Run=0, Busy=0, Finished=0, Error=0, PC=0, InstrCount=0. Memory contents are not cleared.
- Memory: synchronous write; combinational read of mem[PC] and mem[PC+1].
- Outputs are registered or decoded from state; no combinational path from Done to Run or DIN.
- IDLE:
  - LoadEn writes memory.
  - On Start: latch ProgLen; clear PC, InstrCount and Error; Busy=1.
  - If ProgLen==0, go to FINISH.
  - If ProgLen>DEPTH, go to ERR.
  - Otherwise go to CHECK.
- CHECK (1 cycle, Run=0): decode op = mem[PC][8:6].
  - op[2]==1 is illegal (the processor never asserts Done for it): go to ERR.
  - op==001 (mvi) with PC+1 >= ProgLen (missing data word): go to ERR.
  - Otherwise go to ISSUE.
- ISSUE (exactly 1 cycle): DIN=mem[PC], Run=1. The processor latches IR in T0 and moves to T1.
  - mvi: go to DATA.
  - Otherwise: go to WAIT.
- DATA (mvi only): DIN=mem[PC+1], Run=0. The processor consumes the data word in T1 and asserts Done in the same cycle.
  - Done=1: advance by 2.
  - Done=0: go to WAIT.
- WAIT: DIN=0, Run=0. Expected Done arrival, counted from ISSUE:
  - mv: 1 cycle after ISSUE.
  - add/sub: 3 cycles after ISSUE.
  - On Done=1: advance by 1 for mv/add/sub, or by 2 for mvi.
- Advance:
  - PC += step; InstrCount += 1.
  - If new PC >= ProgLen, go to FINISH; else go to CHECK.
  - Next-instruction Run is asserted 2 cycles after the Done cycle.
- Watchdog:
  - Counter cleared in ISSUE; increments each DATA/WAIT cycle without Done.
  - Reaching TIMEOUT goes to ERR.
- FINISH: Finished=1 for 1 cycle; Busy=0; then IDLE.
- ERR: Error=1 (sticky); Busy=0; PC holds the offending address; then IDLE.
- Done outside DATA/WAIT is ignored.
- Reset mid-execution returns to IDLE next edge with Run=0. The processor must share the reset.
- Start and LoadEn in the same cycle while IDLE: the write happens, and the Start is accepted.
- PC arithmetic is AW+1 bits wide internally, so PC+2 at the top address never wraps falsely.

Test Plan:
1. Load mvi r0,5 (001000000, 000000101) and add r0,r0 (010000000); ProgLen=3; Start.
   - Run pulses twice; DIN=0x040 then 0x005 on consecutive cycles.
   - Processor R0=10; InstrCount=2; Finished pulses once; Error=0.
2. mv r1,r0 followed by sub r0,r1, back-to-back.
   - Run gaps match Done timing: 1 cycle for mv, 3 cycles for sub.
   - R0=0 afterwards; PC ends at ProgLen.
3. Word 0x100 (op 100) at address 0; Start.
   - Run never asserted; Error=1; PC=0; Busy falls.
4. mvi as the last word with ProgLen=1.
   - Error=1 with no Run.
   - ProgLen=0 instead: Finished pulses 1 cycle after Start with no Run.
5. Processor model holds Done low.
   - Error asserted exactly TIMEOUT=7 cycles after the ISSUE cycle.
   - A subsequent Start clears Error.
6. Reset asserted during WAIT of an add.
   - Next cycle: Run=0, Busy=0, InstrCount=0.
   - LoadEn pulses while Busy leave memory unchanged (verified by re-execution).
